// File: rtl/mannix_job_sched.sv
// Job scheduler: queues FCC/CNN/POOL/NOP descriptors and runs them one at a time on the accelerators.
// Latency: push->go 2 cycles when idle; done sample->cpl_valid 1 cycle; at least 2 idle cycles between cpl_valid and the next go.
// Backpressure: cmd_ready drops while the FIFO is full (no same-cycle bypass); completions cannot be stalled.
// Optional build macro MANNIX_SCHED_TIMEOUT_EN adds a WAIT watchdog (TIMEOUT_CYCLES) reported through cpl_err.
module mannix_job_sched #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
`ifdef MANNIX_SCHED_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_type,
    input  logic [TAG_W-1:0] cmd_tag,
    input  logic             sw_flush,
    output logic             fc_go,
    input  logic             fc_done,
    output logic             cnn_go,
    input  logic             cnn_done,
    output logic             pool_go,
    input  logic             pool_busy,
    output logic             cpl_valid,
    output logic [1:0]       cpl_type,
    output logic [TAG_W-1:0] cpl_tag,
    output logic             cpl_err,
    output logic [CNT_W-1:0] q_count,
    output logic             sched_busy
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [1:0] T_FCC  = 2'd0;
    localparam logic [1:0] T_CNN  = 2'd1;
    localparam logic [1:0] T_POOL = 2'd2;
    localparam logic [1:0] T_NOP  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_CPL   = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       type_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [1:0]       job_type_q, job_type_d;
    logic [TAG_W-1:0] job_tag_q, job_tag_d;
    logic             seen_busy_q, seen_busy_d;
    logic             flushed_q, flushed_d;
    logic             gap_q;
    logic             fc_go_q, cnn_go_q, pool_go_q;
    logic             fc_go_d, cnn_go_d, pool_go_d;
    logic             cpl_valid_q;
    logic [1:0]       cpl_type_q;
    logic [TAG_W-1:0] cpl_tag_q;
    logic             push, pop;

    assign cmd_ready  = (count_q != CNT_W'(DEPTH));
    // A push arriving together with a flush is dropped along with the queue.
    assign push       = cmd_valid && cmd_ready && !sw_flush;
    assign q_count    = count_q;
    assign sched_busy = (state_q != S_IDLE) || (count_q != '0);
    assign fc_go      = fc_go_q;
    assign cnn_go     = cnn_go_q;
    assign pool_go    = pool_go_q;
    assign cpl_valid  = cpl_valid_q;
    assign cpl_type   = cpl_type_q;
    assign cpl_tag    = cpl_tag_q;

`ifdef MANNIX_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);

    logic [WD_W-1:0] wd_q;
    logic            wd_expired;
    logic            timeout_hit;
    logic            cpl_err_q;

    assign wd_expired = (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    assign cpl_err    = cpl_err_q;

    // Watchdog: zero outside WAIT, so every WAIT entry starts counting from 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (state_q != S_WAIT) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WD_W'(1);
        end
    end

    // Error flag is captured with each completion record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpl_err_q <= 1'b0;
        end else if (state_d == S_CPL) begin
            cpl_err_q <= timeout_hit;
        end
    end
`else
    assign cpl_err = 1'b0;
`endif

    // Job storage; entries are only read while occupied, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push) begin
            type_mem[wr_ptr_q] <= cmd_type;
            tag_mem[wr_ptr_q]  <= cmd_tag;
        end
    end

    // Pointer and occupancy next-state; a flush empties the queue outright.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (sw_flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Scheduler next-state, job latch, pop decision and go selection.
    always_comb begin
        state_d     = state_q;
        job_type_d  = job_type_q;
        job_tag_d   = job_tag_q;
        seen_busy_d = seen_busy_q;
        pop         = 1'b0;
`ifdef MANNIX_SCHED_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                // gap_q holds off one extra cycle after a completion so the
                // memory farm sees a clean gap between engines.
                if (count_q != '0 && !gap_q) begin
                    job_type_d = type_mem[rd_ptr_q];
                    job_tag_d  = tag_mem[rd_ptr_q];
                    state_d    = S_ISSUE;
                end
            end
            S_ISSUE: begin
                seen_busy_d = 1'b0;
                state_d     = (job_type_q == T_NOP) ? S_CPL : S_WAIT;
            end
            S_WAIT: begin
                case (job_type_q)
                    T_FCC:   if (fc_done)  state_d = S_CPL;
                    T_CNN:   if (cnn_done) state_d = S_CPL;
                    T_POOL: begin
                        // Pool only signals busy, so completion is a seen-high-then-low.
                        if (pool_busy) begin
                            seen_busy_d = 1'b1;
                        end else if (seen_busy_q) begin
                            state_d = S_CPL;
                        end
                    end
                    default: state_d = S_CPL;
                endcase
`ifdef MANNIX_SCHED_TIMEOUT_EN
                if (state_d == S_WAIT && wd_expired) begin
                    state_d     = S_CPL;
                    timeout_hit = 1'b1;
                end
`endif
            end
            S_CPL: begin
                // If a flush hit while this job was latched, its FIFO entry is
                // already gone and popping again would underflow.
                pop     = !flushed_q && !sw_flush && (count_q != '0);
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        flushed_d = (state_d == S_IDLE) ? 1'b0 : (flushed_q | sw_flush);
        fc_go_d   = (state_d == S_ISSUE) && (job_type_d == T_FCC);
        cnn_go_d  = (state_d == S_ISSUE) && (job_type_d == T_CNN);
        pool_go_d = (state_d == S_ISSUE) && (job_type_d == T_POOL);
    end

    // Control state, queue bookkeeping and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            job_type_q  <= T_FCC;
            job_tag_q   <= '0;
            seen_busy_q <= 1'b0;
            flushed_q   <= 1'b0;
            gap_q       <= 1'b0;
            fc_go_q     <= 1'b0;
            cnn_go_q    <= 1'b0;
            pool_go_q   <= 1'b0;
            cpl_valid_q <= 1'b0;
            cpl_type_q  <= 2'd0;
            cpl_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            job_type_q  <= job_type_d;
            job_tag_q   <= job_tag_d;
            seen_busy_q <= seen_busy_d;
            flushed_q   <= flushed_d;
            gap_q       <= (state_q == S_CPL);
            fc_go_q     <= fc_go_d;
            cnn_go_q    <= cnn_go_d;
            pool_go_q   <= pool_go_d;
            cpl_valid_q <= (state_d == S_CPL);
            if (state_d == S_CPL) begin
                cpl_type_q <= job_type_q;
                cpl_tag_q  <= job_tag_q;
            end
        end
    end

endmodule

// File: tb/tb_mannix_job_sched.sv
`timescale 1ns/1ps
module tb_mannix_job_sched;

    localparam int DEPTH = 4;
    localparam int TAG_W = 8;
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] T_FCC  = 2'd0;
    localparam logic [1:0] T_CNN  = 2'd1;
    localparam logic [1:0] T_POOL = 2'd2;
    localparam logic [1:0] T_NOP  = 2'd3;

`ifdef MANNIX_SCHED_TIMEOUT_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_type;
    logic [TAG_W-1:0] cmd_tag;
    logic             sw_flush;
    logic             fc_go, fc_done;
    logic             cnn_go, cnn_done;
    logic             pool_go, pool_busy;
    logic             cpl_valid;
    logic [1:0]       cpl_type;
    logic [TAG_W-1:0] cpl_tag;
    logic             cpl_err;
    logic [CNT_W-1:0] q_count;
    logic             sched_busy;

    int n_assert = 0;
    int n_fail   = 0;

    // Scoreboard: completion records {err,type,tag} and expected go units, in order.
    logic [TAG_W+2:0] exp_cpl[$];
    logic [1:0]       exp_go[$];

    int   cyc          = 0;
    int   last_cpl_cyc = -100;
    int   go_cnt       = 0;
    int   go_since_cpl = 0;
    logic prev_go      = 1'b0;

    mannix_job_sched #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W),
        .CNT_W(CNT_W)
`ifdef MANNIX_SCHED_TIMEOUT_EN
        , .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type), .cmd_tag(cmd_tag),
        .sw_flush(sw_flush),
        .fc_go(fc_go), .fc_done(fc_done),
        .cnn_go(cnn_go), .cnn_done(cnn_done),
        .pool_go(pool_go), .pool_busy(pool_busy),
        .cpl_valid(cpl_valid), .cpl_type(cpl_type), .cpl_tag(cpl_tag), .cpl_err(cpl_err),
        .q_count(q_count), .sched_busy(sched_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL tb_watchdog: simulation did not finish, observed time %0t", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2:0] onehot(input logic [1:0] t);
        case (t)
            T_FCC:   return 3'b100;
            T_CNN:   return 3'b010;
            T_POOL:  return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one job for one edge; record it if the FIFO had room.
    task automatic push_job(input logic [1:0] t, input logic [TAG_W-1:0] g);
        logic rdy;
        cmd_valid = 1'b1;
        cmd_type  = t;
        cmd_tag   = g;
        rdy       = cmd_ready;
        step();
        if (rdy) begin
            exp_cpl.push_back({1'b0, t, g});
            if (t != T_NOP) exp_go.push_back(t);
        end
    endtask

    // Wait for the next job to start, answer it like the engine would, wait for its completion.
    task automatic serve_one();
        int k = 0;
        while (!(fc_go || cnn_go || pool_go || cpl_valid) && k < 60) begin
            step();
            k++;
        end
        chk("serve_start_in_time", 32'(k < 60), 32'd1);
        if (fc_go) begin
            step(); fc_done = 1'b1; step(); fc_done = 1'b0;
        end else if (cnn_go) begin
            step(); step(); cnn_done = 1'b1; step(); cnn_done = 1'b0;
        end else if (pool_go) begin
            step(); pool_busy = 1'b1; repeat (3) step(); pool_busy = 1'b0; step();
        end
        k = 0;
        while (!cpl_valid && k < 20) begin
            step();
            k++;
        end
        chk("serve_cpl_in_time", 32'(cpl_valid), 32'd1);
        step();
    endtask

    // Output monitor: go legality/order and completion records against the scoreboard.
    always @(negedge clk) begin
        logic [2:0]       gos;
        logic [TAG_W+2:0] e;
        gos = {fc_go, cnn_go, pool_go};
        cyc++;
        if (rst_n) begin
            if (gos != 3'b000) begin
                chk("go_onehot", 32'($countones(gos)), 32'd1);
                chk("go_single_cycle", 32'(prev_go), 32'd0);
                chk("go_gap_after_cpl", 32'((cyc - last_cpl_cyc) >= 3), 32'd1);
                chk("go_expected_pending", 32'(exp_go.size() != 0), 32'd1);
                if (exp_go.size() != 0) chk("go_unit", 32'(gos), 32'(onehot(exp_go.pop_front())));
                go_cnt++;
                go_since_cpl++;
            end
            if (cpl_valid) begin
                chk("cpl_expected_pending", 32'(exp_cpl.size() != 0), 32'd1);
                if (exp_cpl.size() != 0) begin
                    e = exp_cpl.pop_front();
                    chk("cpl_record", 32'({cpl_err, cpl_type, cpl_tag}), 32'(e));
                    chk("cpl_go_count", 32'(go_since_cpl),
                        (e[TAG_W+1:TAG_W] != T_NOP) ? 32'd1 : 32'd0);
                end
                go_since_cpl = 0;
                last_cpl_cyc = cyc;
            end
            prev_go = (gos != 3'b000);
        end
    end

    initial begin
        int   k;
        int   base_go;
        logic seen;

        cmd_valid = 1'b0; cmd_type = 2'd0; cmd_tag = '0; sw_flush = 1'b0;
        fc_done = 1'b0; cnn_done = 1'b0; pool_busy = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();

        // Reset state
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_sched_busy", 32'(sched_busy), 32'd0);
        chk("rst_gos", 32'({fc_go, cnn_go, pool_go}), 32'd0);
        chk("rst_cpl", 32'({cpl_valid, cpl_err, cpl_type, cpl_tag}), 32'd0);
        rst_n = 1'b1;
        repeat (2) step();

        // Single FCC job: go two cycles after the push, completion one cycle after done
        push_job(T_FCC, 8'h11);
        cmd_valid = 1'b0;
        chk("t1_q_count_after_push", 32'(q_count), 32'd1);
        chk("t1_busy_after_push", 32'(sched_busy), 32'd1);
        chk("t1_fc_go_early", 32'(fc_go), 32'd0);
        step();
        chk("t1_fc_go_on_time", 32'(fc_go), 32'd1);
        step();
        chk("t1_fc_go_dropped", 32'(fc_go), 32'd0);
        repeat (3) step();
        fc_done = 1'b1;
        step();
        fc_done = 1'b0;
        chk("t1_cpl_valid", 32'(cpl_valid), 32'd1);
        chk("t1_q_count_in_cpl", 32'(q_count), 32'd1);
        step();
        chk("t1_cpl_one_cycle", 32'(cpl_valid), 32'd0);
        chk("t1_q_count_after_pop", 32'(q_count), 32'd0);
        repeat (3) step();
        chk("t1_cpl_tag_held", 32'({cpl_type, cpl_tag}), 32'({T_FCC, 8'h11}));
        chk("t1_idle", 32'(sched_busy), 32'd0);

        // Four mixed jobs back-to-back fill the FIFO
        push_job(T_CNN, 8'h21);
        push_job(T_POOL, 8'h22);
        push_job(T_NOP, 8'h23);
        chk("t2_ready_before_last", 32'(cmd_ready), 32'd1);
        push_job(T_FCC, 8'h24);
        cmd_valid = 1'b0;
        chk("t2_ready_full", 32'(cmd_ready), 32'd0);
        chk("t2_q_count_full", 32'(q_count), 32'd4);
        // The CNN job has already been issued and sits in WAIT.
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        chk("t2_cnn_cpl", 32'(cpl_valid), 32'd1);
        step();
        repeat (3) serve_one();
        chk("t2_drained", 32'(q_count), 32'd0);

        // POOL completes only after busy has been seen high and then low
        push_job(T_POOL, 8'h31);
        cmd_valid = 1'b0;
        k = 0;
        while (!pool_go && k < 20) begin step(); k++; end
        chk("t3_pool_go_seen", 32'(pool_go), 32'd1);
        seen = 1'b0;
        repeat (6) begin step(); seen = seen | cpl_valid; end
        pool_busy = 1'b1;
        repeat (10) begin step(); seen = seen | cpl_valid; end
        chk("t3_no_cpl_before_fall", 32'(seen), 32'd0);
        pool_busy = 1'b0;
        step();
        chk("t3_cpl_after_fall", 32'(cpl_valid), 32'd1);
        step();
        chk("t3_single_cpl", 32'(cpl_valid), 32'd0);
        repeat (3) step();

        // Full FIFO with a held request: accepted only once q_count reads 3
        push_job(T_FCC, 8'h41);
        push_job(T_FCC, 8'h42);
        push_job(T_FCC, 8'h43);
        push_job(T_FCC, 8'h44);
        cmd_valid = 1'b1; cmd_type = T_FCC; cmd_tag = 8'h45;
        repeat (2) step();
        chk("t4_held_not_taken", 32'(q_count), 32'd4);
        fc_done = 1'b1;
        step();
        fc_done = 1'b0;
        chk("t4_cpl_valid", 32'(cpl_valid), 32'd1);
        chk("t4_no_bypass_count", 32'(q_count), 32'd4);
        chk("t4_no_bypass_ready", 32'(cmd_ready), 32'd0);
        step();
        chk("t4_count_after_pop", 32'(q_count), 32'd3);
        chk("t4_ready_after_pop", 32'(cmd_ready), 32'd1);
        step();
        exp_cpl.push_back({1'b0, T_FCC, 8'h45});
        exp_go.push_back(T_FCC);
        cmd_valid = 1'b0;
        chk("t4_held_taken", 32'(q_count), 32'd4);
        repeat (4) serve_one();

        // Flush during WAIT of job A with three queued behind it
        push_job(T_CNN, 8'h51);
        push_job(T_FCC, 8'h52);
        push_job(T_FCC, 8'h53);
        push_job(T_FCC, 8'h54);
        cmd_type = T_FCC; cmd_tag = 8'h55;
        sw_flush = 1'b1;
        step();
        sw_flush = 1'b0;
        cmd_valid = 1'b0;
        while (exp_cpl.size() > 1) void'(exp_cpl.pop_back());
        exp_go.delete();
        base_go = go_cnt;
        chk("t5_flush_count", 32'(q_count), 32'd0);
        chk("t5_flush_busy", 32'(sched_busy), 32'd1);
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        chk("t5_inflight_cpl", 32'(cpl_valid), 32'd1);
        step();
        chk("t5_no_underflow", 32'(q_count), 32'd0);
        chk("t5_idle_after", 32'(sched_busy), 32'd0);
        // A push in the flush cycle is discarded even with room available
        cmd_valid = 1'b1; cmd_type = T_FCC; cmd_tag = 8'h66;
        sw_flush = 1'b1;
        step();
        sw_flush = 1'b0;
        cmd_valid = 1'b0;
        chk("t5_push_dropped", 32'(q_count), 32'd0);
        repeat (10) step();
        chk("t5_no_further_go", 32'(go_cnt - base_go), 32'd0);

        // CNN job whose done never arrives in time; the following job must still run
        cmd_valid = 1'b1; cmd_type = T_CNN; cmd_tag = 8'h71;
        step();
        exp_cpl.push_back({ERR_EXP, T_CNN, 8'h71});
        exp_go.push_back(T_CNN);
        push_job(T_FCC, 8'h72);
        cmd_valid = 1'b0;
        k = 0;
        while (!cnn_go && k < 20) begin step(); k++; end
        chk("t6_cnn_go_seen", 32'(cnn_go), 32'd1);
`ifdef MANNIX_SCHED_TIMEOUT_EN
        k = 0;
        while (!cpl_valid && k < 40) begin step(); k++; end
        chk("t6_timeout_latency", 32'(k), 32'd17);
        chk("t6_timeout_err", 32'(cpl_err), 32'd1);
        step();
`else
        seen = 1'b0;
        repeat (40) begin step(); seen = seen | cpl_valid; end
        chk("t6_wait_unbounded", 32'(seen), 32'd0);
        cnn_done = 1'b1;
        step();
        cnn_done = 1'b0;
        chk("t6_late_done_cpl", 32'(cpl_valid), 32'd1);
        chk("t6_err_tied_low", 32'(cpl_err), 32'd0);
        step();
`endif
        serve_one();
        chk("t6_err_cleared", 32'(cpl_err), 32'd0);

        repeat (3) step();
        chk("sb_cpl_drained", 32'(exp_cpl.size()), 32'd0);
        chk("sb_go_drained", 32'(exp_go.size()), 32'd0);
        chk("final_idle", 32'({sched_busy, q_count}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
